// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs word loads/stores against a variable-latency data memory
// over req/ack, stalls the upstream pipeline while waiting, and owns the MEM/WB register.
module mem_access_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5   // 2**CNT_W must exceed TIMEOUT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] ALUresult_i,
  input  logic [31:0] Readdata2_i,
  input  logic [4:0]  INS_11_7_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic [31:0] ALUresult_o,
  output logic [31:0] MemData_o,
  output logic [4:0]  INS_11_7_o,
  output logic        misalign_o,
  output logic        timeout_o,
  output logic [1:0]  state_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  // Memory handshake: mem_req_o rises together with mem_addr_o/mem_we_o/mem_wdata_o,
  // and all four stay frozen until the edge that samples a mem_ack_i pulse or the
  // timeout expires; mem_ack_i is honoured only while BUSY and ignored otherwise.
  logic [1:0]       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      rdata_q;
  logic             memop;
  logic             aligned;
  logic             load_op;
  logic             start;
  logic             wb_bubble;

  always_comb begin
    memop     = MemRead_i | MemWrite_i;
    aligned   = (ALUresult_i[1:0] == 2'b00);
    load_op   = MemRead_i & ~MemWrite_i;
    start     = (state_q == S_IDLE) && memop && aligned;
    // Anything that is not a completed instruction must not write back.
    wb_bubble = ((state_q == S_IDLE) && memop) || (state_q == S_BUSY);
    stall_o   = start || (state_q == S_BUSY);
  end

  assign state_o = state_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rdata_q     <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      misalign_o  <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          misalign_o <= memop & ~aligned;
          if (start) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= MemWrite_i;
            mem_addr_o  <= {ALUresult_i[31:2], 2'b00};
            mem_wdata_o <= Readdata2_i;
            cnt_q       <= '0;
            state_q     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            if (!MemWrite_i) rdata_q <= mem_rdata_i;
            state_q <= S_DONE;
          end else if (cnt_q == CNT_LAST) begin
            // Abort: a timed-out load writes back zero.
            mem_req_o <= 1'b0;
            timeout_o <= 1'b1;
            rdata_q   <= '0;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      RegWrite_o  <= 1'b0;
      MemtoReg_o  <= 1'b0;
      ALUresult_o <= '0;
      MemData_o   <= '0;
      INS_11_7_o  <= '0;
    end else begin
      RegWrite_o  <= wb_bubble ? 1'b0 : RegWrite_i;
      MemtoReg_o  <= wb_bubble ? 1'b0 : MemtoReg_i;
      ALUresult_o <= ALUresult_i;
      INS_11_7_o  <= INS_11_7_i;
      if ((state_q == S_DONE) && load_op) MemData_o <= rdata_q;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage: upstream driver, memory responder, and a
// write-back monitor that compares against a transaction-level model via exp_q.
module tb_mem_access_stage;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 5;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
  logic [31:0] ALUresult_i, Readdata2_i;
  logic [4:0]  INS_11_7_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o, RegWrite_o, MemtoReg_o;
  logic [31:0] ALUresult_o, MemData_o;
  logic [4:0]  INS_11_7_o;
  logic        misalign_o, timeout_o;
  logic [1:0]  dut_state;

  mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .ALUresult_i(ALUresult_i), .Readdata2_i(Readdata2_i), .INS_11_7_i(INS_11_7_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
    .ALUresult_o(ALUresult_o), .MemData_o(MemData_o), .INS_11_7_o(INS_11_7_o),
    .misalign_o(misalign_o), .timeout_o(timeout_o), .state_o(dut_state)
  );

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic        rw;
    logic        mtr;
    logic        chk_data;
    logic        chk_req_low;
    logic        misalign;
    logic        tmo;
    logic [7:0]  stall;
    logic [31:0] alu;
    logic [31:0] data;
    logic [4:0]  rd;
  } wb_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic [7:0]  delay;   // 0 = never acknowledge
    logic [31:0] rdata;
  } resp_t;

  wb_t   exp_q[$];
  req_t  req_q[$];
  resp_t resp_q[$];
  logic [31:0] mem_model [logic [31:0]];

  int   checks = 0;
  int   passes = 0;
  logic tmo_model = 1'b0;
  logic cur_valid = 1'b0;
  logic mon_en = 1'b0;
  logic resp_en = 1'b0;
  logic stray_pending = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- driver tasks (upstream EX/MEM) ----------------
  task automatic drive_zero();
    RegWrite_i = 0; MemtoReg_i = 0; MemRead_i = 0; MemWrite_i = 0;
    ALUresult_i = '0; Readdata2_i = '0; INS_11_7_i = '0;
  endtask

  task automatic idle(input int n);
    drive_zero();
    cur_valid = 1'b0;
    repeat (n) @(negedge clk_i);
  endtask

  // Presents one instruction and holds it until the stage accepts it.
  task automatic issue(input logic rw, input logic mtr, input logic rd_en, input logic wr_en,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                       input int delay);
    wb_t e; req_t q; resp_t r;
    logic memop, aligned, load, st, done;
    logic [31:0] word, rdata;
    memop   = rd_en | wr_en;
    aligned = (alu[1:0] == 2'b00);
    load    = rd_en & ~wr_en;
    word    = {alu[31:2], 2'b00};
    e = '0;
    e.rw  = (memop && !aligned) ? 1'b0 : rw;
    e.mtr = (memop && !aligned) ? 1'b0 : mtr;
    e.alu = alu;
    e.rd  = rd;
    e.misalign = memop & ~aligned;
    if (memop && aligned) begin
      e.stall = (delay == 0) ? 8'(TIMEOUT + 1) : 8'(delay + 1);
      if (delay == 0) tmo_model = 1'b1;
      rdata = $urandom;
      if (load) begin
        if (delay == 0) rdata = '0;
        else if (mem_model.exists(word)) rdata = mem_model[word];
        else mem_model[word] = rdata;
        e.chk_data = 1'b1;
        e.data = rdata;
      end else if (delay != 0) begin
        mem_model[word] = wd;
      end
      q.we = wr_en; q.addr = word; q.wdata = wd;
      r.delay = 8'(delay); r.rdata = rdata;
      req_q.push_back(q);
      resp_q.push_back(r);
    end else begin
      e.chk_req_low = 1'b1;
    end
    e.tmo = tmo_model;
    exp_q.push_back(e);

    RegWrite_i = rw; MemtoReg_i = mtr; MemRead_i = rd_en; MemWrite_i = wr_en;
    ALUresult_i = alu; Readdata2_i = wd; INS_11_7_i = rd;
    cur_valid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      #1 st = stall_o;
      @(negedge clk_i);
      if (!st) done = 1'b1;
    end
    if (!done) check("issue_accept_timeout", 32'd1, 32'd0);
  endtask

  // ---------------- memory responder ----------------
  task automatic serve();
    req_t q; resp_t r;
    if (req_q.size() == 0 || resp_q.size() == 0) begin
      check("unexpected_req", 32'd1, 32'd0);
      return;
    end
    q = req_q.pop_front();
    r = resp_q.pop_front();
    check("req_addr", mem_addr_o, q.addr);
    check("req_we", 32'(mem_we_o), 32'(q.we));
    check("req_wdata", mem_wdata_o, q.wdata);
    for (int c = 1; c <= TIMEOUT; c++) begin
      if (r.delay != 0 && c == int'(r.delay)) begin
        mem_ack_i = 1'b1;
        mem_rdata_i = r.rdata;
        return;
      end
      if (r.delay == 0 && c == TIMEOUT) begin
        @(negedge clk_i); #1;
        check("timeout_req_drop", 32'(mem_req_o), 32'd0);
        stray_pending = 1'b1;
        return;
      end
      @(negedge clk_i); #1;
      check("req_hold", 32'(mem_req_o), 32'd1);
      check("addr_hold", mem_addr_o, q.addr);
    end
  endtask

  always begin
    @(negedge clk_i); #1;
    if (resp_en) begin
      mem_ack_i = 1'b0;
      mem_rdata_i = $urandom;
      if (stray_pending) begin
        mem_ack_i = 1'b1;
        stray_pending = 1'b0;
      end else if (mem_req_o) begin
        serve();
      end
    end
  end

  // ---------------- write-back monitor ----------------
  logic prev_valid = 1'b0;
  logic prev_stall = 1'b0;
  int   stall_cnt  = 0;
  wb_t  me;

  always begin
    @(negedge clk_i); #2;
    if (!mon_en) begin
      prev_valid = 1'b0;
      prev_stall = 1'b0;
      stall_cnt  = 0;
    end else begin
      if (prev_valid && prev_stall)
        check("bubble_regwrite", {30'd0, RegWrite_o, MemtoReg_o}, 32'd0);
      if (prev_valid && !prev_stall) begin
        if (exp_q.size() == 0) begin
          check("exp_q_underflow", 32'd1, 32'd0);
        end else begin
          me = exp_q.pop_front();
          check("wb_regwrite", 32'(RegWrite_o), 32'(me.rw));
          check("wb_memtoreg", 32'(MemtoReg_o), 32'(me.mtr));
          check("wb_aluresult", ALUresult_o, me.alu);
          check("wb_rd", 32'(INS_11_7_o), 32'(me.rd));
          check("misalign", 32'(misalign_o), 32'(me.misalign));
          check("timeout_flag", 32'(timeout_o), 32'(me.tmo));
          check("stall_cycles", 32'(stall_cnt), 32'(me.stall));
          if (me.chk_data) check("wb_memdata", MemData_o, me.data);
          if (me.chk_req_low) check("no_req", 32'(mem_req_o), 32'd0);
        end
        stall_cnt = 0;
      end
      if (cur_valid && stall_o) stall_cnt++;
      prev_valid = cur_valid;
      prev_stall = stall_o;
    end
  end

  // ---------------- main stimulus ----------------
  initial begin
    int k, d;
    logic [31:0] a;
    rst_i = 1'b0;
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    drive_zero();
    repeat (3) @(negedge clk_i);
    #2;
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_regwrite", 32'(RegWrite_o), 32'd0);
    check("rst_aluresult", ALUresult_o, 32'd0);
    check("rst_memdata", MemData_o, 32'd0);
    check("rst_timeout", 32'(timeout_o), 32'd0);
    check("rst_misalign", 32'(misalign_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    mon_en = 1'b1;
    resp_en = 1'b1;
    idle(1);

    // Directed cases
    issue(1, 0, 0, 0, 32'h0000_0042, 32'h0, 5'd5, 0);
    mem_model[32'h100] = 32'hDEAD_BEEF;
    issue(1, 1, 1, 0, 32'h0000_0100, 32'h0, 5'd10, 3);
    issue(0, 0, 0, 1, 32'h0000_0204, 32'h1234_5678, 5'd0, 1);
    issue(1, 1, 1, 0, 32'h0000_0103, 32'h0, 5'd11, 2);
    issue(1, 1, 1, 0, 32'h0000_0108, 32'h0, 5'd12, 0);
    issue(1, 0, 0, 0, 32'h0000_0077, 32'h0, 5'd13, 0);
    issue(1, 1, 1, 0, 32'h0000_0204, 32'h0, 5'd14, 2);
    idle(2);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 9);
      d = ($urandom_range(0, 24) == 0) ? 0 : $urandom_range(1, 5);
      a = 32'h100 + (32'($urandom_range(0, 15)) << 2);
      case (k)
        0, 1, 2: issue(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, $urandom, $urandom,
                       5'($urandom_range(0, 31)), 0);
        3, 4, 5: issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0, a,
                       $urandom, 5'($urandom_range(0, 31)), d);
        6, 7:    issue(1'b0, 1'b0, 1'b0, 1'b1, a, $urandom, 5'($urandom_range(0, 31)), d);
        8:       issue(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b1,
                       a + 32'($urandom_range(1, 3)), $urandom, 5'($urandom_range(0, 31)), d);
        default: issue(1'b1, 1'b1, 1'b1, 1'b1, a, $urandom, 5'($urandom_range(0, 31)), d);
      endcase
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(4);
    check("exp_q_drained_pre_reset", 32'(exp_q.size()), 32'd0);

    // Reset in the 2nd BUSY cycle of a load; a following ack must be ignored.
    mon_en = 1'b0;
    resp_en = 1'b0;
    mem_ack_i = 1'b0;
    RegWrite_i = 1; MemtoReg_i = 1; MemRead_i = 1; MemWrite_i = 0;
    ALUresult_i = 32'h300; Readdata2_i = 32'h0; INS_11_7_i = 5'd7;
    @(negedge clk_i); #2;
    check("rst_test_busy_req", 32'(mem_req_o), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    drive_zero();
    rst_i = 1'b1;
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'hFFFF_FFFF;
    #2;
    check("midrst_req", 32'(mem_req_o), 32'd0);
    check("midrst_stall", 32'(stall_o), 32'd0);
    check("midrst_regwrite", 32'(RegWrite_o), 32'd0);
    check("midrst_memtoreg", 32'(MemtoReg_o), 32'd0);
    check("midrst_aluresult", ALUresult_o, 32'd0);
    check("midrst_memdata", MemData_o, 32'd0);
    check("midrst_rd", 32'(INS_11_7_o), 32'd0);
    check("midrst_timeout", 32'(timeout_o), 32'd0);
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    #2;
    check("late_ack_req", 32'(mem_req_o), 32'd0);
    check("late_ack_stall", 32'(stall_o), 32'd0);
    check("late_ack_memdata", MemData_o, 32'd0);
    check("late_ack_timeout", 32'(timeout_o), 32'd0);
    @(negedge clk_i);
    tmo_model = 1'b0;
    mon_en = 1'b1;
    resp_en = 1'b1;
    idle(1);
    issue(1, 0, 0, 0, 32'h0000_0055, 32'h0, 5'd3, 0);
    issue(1, 1, 1, 0, 32'h0000_0100, 32'h0, 5'd9, 2);
    idle(3);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, state=%0d, required finished", dut_state);
    $fatal(1, "watchdog expired");
  end

endmodule
